// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Key codes, ALU op codes and sequencer states for the calculator.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int CALC_ERR_CODE  = 9999;
    localparam int CALC_MAX_VALUE = 9999;

    localparam logic [3:0] KEY_ADD  = 4'd10;
    localparam logic [3:0] KEY_SUB  = 4'd11;
    localparam logic [3:0] KEY_MULT = 4'd12;
    localparam logic [3:0] KEY_DIV  = 4'd13;
    localparam logic [3:0] KEY_EQ   = 4'd14;
    localparam logic [3:0] KEY_CLR  = 4'd15;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MULT = 2'd2;
    localparam logic [1:0] OP_DIV  = 2'd3;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_WAIT = 3'd4,
        S_RES  = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] key);
        return (key >= KEY_ADD) && (key <= KEY_DIV);
    endfunction

    // Operator keys are contiguous and ordered like the ALU op codes.
    function automatic logic [1:0] key_to_op(input logic [3:0] key);
        logic [3:0] t;
        t = key - KEY_ADD;
        return t[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_operand_acc.sv
`default_nettype none
// ============================================================================
// Module      : calc_operand_acc
// Description : Decimal operand accumulator with digit counter and digit limit.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_operand_acc #(
    parameter int DATA_W     = 14,
    parameter int MAX_DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load_digit,
    input  logic              append,
    input  logic              load_value,
    input  logic [3:0]        digit,
    input  logic [DATA_W-1:0] value_in,
    output logic [DATA_W-1:0] value
);

    localparam int                 c_CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam int                 c_TEN_INT = 10;
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = MAX_DIGITS[c_CNT_W-1:0];
    localparam logic [DATA_W-1:0]  c_TEN     = c_TEN_INT[DATA_W-1:0];

    logic [DATA_W-1:0]  r_value;
    logic [c_CNT_W-1:0] r_count;
    logic [DATA_W-1:0]  w_append;

    // The digit limit keeps acc*10+d within range, so truncation never drops bits.
    assign w_append = (r_value * c_TEN) + {{(DATA_W-4){1'b0}}, digit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_value <= '0;
            r_count <= '0;
        end else if (load_value) begin
            r_value <= value_in;
            r_count <= c_MAX_CNT;
        end else if (load_digit) begin
            r_value <= {{(DATA_W-4){1'b0}}, digit};
            r_count <= {{(c_CNT_W-1){1'b0}}, 1'b1};
        end else if (append && (r_count < c_MAX_CNT)) begin
            r_value <= w_append;
            r_count <= r_count + 1'b1;
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calc_sequencer
// Description : Keypad-driven sequencer for the shared calculator ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int MAX_DIGITS = 4,
    parameter int ERR_CODE   = CALC_ERR_CODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic              key_ready,
    input  logic [DATA_W-1:0] alu_result,
    output logic [1:0]        operation_val,
    output logic              op_enable,
    output logic              eq_enable,
    output logic [DATA_W-1:0] operator1,
    output logic [DATA_W-1:0] operator2,
    output logic [DATA_W-1:0] display_value,
    output logic              error,
    output logic              busy
);

    localparam logic [DATA_W:0]     c_MAX_SUM   = CALC_MAX_VALUE[DATA_W:0];
    localparam logic [2*DATA_W-1:0] c_MAX_PROD  = CALC_MAX_VALUE[2*DATA_W-1:0];
    localparam logic [DATA_W-1:0]   c_ERR_VALUE = ERR_CODE[DATA_W-1:0];

    state_t            r_state;
    logic [1:0]        r_op;
    logic [1:0]        r_next_op;
    logic              r_chain;
    logic              r_key_ready;
    logic              r_op_enable;
    logic              r_eq_enable;
    logic              r_error;
    logic [DATA_W-1:0] r_operator1;
    logic [DATA_W-1:0] r_operator2;
    logic [DATA_W-1:0] r_display;

    logic                w_accept;
    logic                w_is_digit;
    logic                w_is_op;
    logic                w_is_eq;
    logic                w_is_clr;
    logic                w_ok;
    logic [DATA_W-1:0]   w_acc_a;
    logic [DATA_W-1:0]   w_acc_b;
    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_prod;

    assign w_accept   = key_valid && r_key_ready;
    assign w_is_digit = is_digit(key_code);
    assign w_is_op    = is_op(key_code);
    assign w_is_eq    = (key_code == KEY_EQ);
    assign w_is_clr   = (key_code == KEY_CLR);

    calc_operand_acc #(
        .DATA_W     (DATA_W),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_acc_a (
        .clk        (clk),
        .rst        (rst),
        .clr        (w_accept && w_is_clr),
        .load_digit (w_accept && w_is_digit && (r_state == S_RES)),
        .append     (w_accept && w_is_digit && (r_state == S_A)),
        .load_value (r_state == S_WAIT),
        .digit      (key_code),
        .value_in   (alu_result),
        .value      (w_acc_a)
    );

    calc_operand_acc #(
        .DATA_W     (DATA_W),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_acc_b (
        .clk        (clk),
        .rst        (rst),
        .clr        ((w_accept && w_is_clr) || (r_state == S_WAIT)),
        .load_digit (w_accept && w_is_digit && (r_state == S_OP)),
        .append     (w_accept && w_is_digit && (r_state == S_B)),
        .load_value (1'b0),
        .digit      (key_code),
        .value_in   ('0),
        .value      (w_acc_b)
    );

    // Operands are final when the launching key is accepted, so the check is
    // made then and carried into S_EXEC through r_op_enable.
    assign w_sum  = {1'b0, w_acc_a} + {1'b0, w_acc_b};
    assign w_prod = {{DATA_W{1'b0}}, w_acc_a} * {{DATA_W{1'b0}}, w_acc_b};

    always_comb begin
        w_ok = 1'b0;
        case (r_op)
            OP_ADD:  w_ok = (w_sum <= c_MAX_SUM);
            OP_SUB:  w_ok = (w_acc_a >= w_acc_b);
            OP_MULT: w_ok = (w_prod <= c_MAX_PROD);
            default: w_ok = (w_acc_b != '0);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_A;
            r_op        <= OP_ADD;
            r_next_op   <= OP_ADD;
            r_chain     <= 1'b0;
            r_key_ready <= 1'b1;
            r_op_enable <= 1'b0;
            r_eq_enable <= 1'b0;
            r_error     <= 1'b0;
            r_operator1 <= '0;
            r_operator2 <= '0;
            r_display   <= '0;
        end else begin
            r_op_enable <= 1'b0;
            r_eq_enable <= 1'b0;
            r_operator1 <= w_acc_a;
            r_operator2 <= w_acc_b;
            case (r_state)
                S_B:     r_display <= w_acc_b;
                S_ERR:   r_display <= c_ERR_VALUE;
                default: r_display <= w_acc_a;
            endcase

            if (w_accept && w_is_clr) begin
                r_state   <= S_A;
                r_op      <= OP_ADD;
                r_next_op <= OP_ADD;
                r_chain   <= 1'b0;
                r_error   <= 1'b0;
            end else begin
                case (r_state)
                    S_A: begin
                        if (w_accept && w_is_op) begin
                            r_op    <= key_to_op(key_code);
                            r_state <= S_OP;
                        end
                    end
                    S_OP: begin
                        if (w_accept && w_is_op) begin
                            r_op <= key_to_op(key_code);
                        end else if (w_accept && w_is_digit) begin
                            r_state <= S_B;
                        end
                    end
                    S_B: begin
                        if (w_accept && (w_is_eq || w_is_op)) begin
                            r_chain     <= w_is_op;
                            r_next_op   <= key_to_op(key_code);
                            r_op_enable <= w_ok;
                            r_eq_enable <= w_ok && w_is_eq;
                            r_key_ready <= 1'b0;
                            r_state     <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        if (r_op_enable) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_state     <= S_ERR;
                            r_error     <= 1'b1;
                            r_key_ready <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        r_key_ready <= 1'b1;
                        if (r_chain) begin
                            r_op    <= r_next_op;
                            r_state <= S_OP;
                        end else begin
                            r_state <= S_RES;
                        end
                    end
                    S_RES: begin
                        if (w_accept && w_is_op) begin
                            r_op    <= key_to_op(key_code);
                            r_state <= S_OP;
                        end else if (w_accept && w_is_digit) begin
                            r_state <= S_A;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign key_ready     = r_key_ready;
    assign busy          = ~r_key_ready;
    assign op_enable     = r_op_enable;
    assign eq_enable     = r_eq_enable;
    assign operation_val = r_op;
    assign operator1     = r_operator1;
    assign operator2     = r_operator2;
    assign display_value = r_display;
    assign error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_sequencer
// Description : Self-checking bench for calc_sequencer with a keystroke-level calculator model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_sequencer;

    localparam int DATA_W = 14;
    localparam int M_A    = 0;
    localparam int M_OP   = 1;
    localparam int M_B    = 2;
    localparam int M_RES  = 3;
    localparam int M_ERR  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              key_valid;
    logic [3:0]        key_code;
    logic              key_ready;
    logic [DATA_W-1:0] alu_result;
    logic [1:0]        operation_val;
    logic              op_enable;
    logic              eq_enable;
    logic [DATA_W-1:0] operator1;
    logic [DATA_W-1:0] operator2;
    logic [DATA_W-1:0] display_value;
    logic              error;
    logic              busy;

    calc_sequencer #(
        .DATA_W     (DATA_W),
        .MAX_DIGITS (4),
        .ERR_CODE   (9999)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_ready     (key_ready),
        .alu_result    (alu_result),
        .operation_val (operation_val),
        .op_enable     (op_enable),
        .eq_enable     (eq_enable),
        .operator1     (operator1),
        .operator2     (operator2),
        .display_value (display_value),
        .error         (error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int arith(input int op, input int a, input int b);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return a * b;
            default: return (b == 0) ? 0 : a / b;
        endcase
    endfunction

    // Registered ALU stand-in: result visible the cycle after op_enable.
    always @(posedge clk) begin
        if (op_enable) begin
            alu_result <= DATA_W'(arith(int'(operation_val), int'(operator1), int'(operator2)));
        end
    end

    // ---------------- calculator model ----------------
    typedef struct {
        int op;
        int a;
        int b;
        int eq;
    } launch_t;

    launch_t exp_q[$];
    int m_mode, m_a, m_b, m_ca, m_cb, m_op;

    task automatic m_reset();
        m_mode = M_A; m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_op = 0;
        exp_q.delete();
    endtask

    function automatic bit m_ok(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) <= 9999;
            1:       return a >= b;
            2:       return (a * b) <= 9999;
            default: return b != 0;
        endcase
    endfunction

    task automatic m_exec(input int chain, input int nxt);
        launch_t l;
        if (!m_ok(m_op, m_a, m_b)) begin
            m_mode = M_ERR;
            return;
        end
        l.op = m_op; l.a = m_a; l.b = m_b; l.eq = chain ? 0 : 1;
        exp_q.push_back(l);
        m_a = arith(m_op, m_a, m_b);
        m_b = 0;
        if (chain != 0) begin
            m_op = nxt;
            m_mode = M_OP;
        end else begin
            m_mode = M_RES;
        end
    endtask

    task automatic m_key(input int k);
        if (k == 15) begin
            m_mode = M_A; m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_op = 0;
            return;
        end
        if (m_mode == M_ERR) return;
        if (k <= 9) begin
            if (m_mode == M_A) begin
                if (m_ca < 4) begin m_a = m_a * 10 + k; m_ca++; end
            end else if (m_mode == M_OP) begin
                m_b = k; m_cb = 1; m_mode = M_B;
            end else if (m_mode == M_B) begin
                if (m_cb < 4) begin m_b = m_b * 10 + k; m_cb++; end
            end else if (m_mode == M_RES) begin
                m_a = k; m_ca = 1; m_mode = M_A;
            end
        end else if (k <= 13) begin
            if (m_mode == M_B) m_exec(1, k - 10);
            else begin m_op = k - 10; m_mode = M_OP; end
        end else if (m_mode == M_B) begin
            m_exec(0, 0);
        end
    endtask

    function automatic int m_disp();
        if (m_mode == M_B) return m_b;
        if (m_mode == M_ERR) return 9999;
        return m_a;
    endfunction

    // ---------------- launch / handshake compare ----------------
    int l_cnt = 0;
    int l_op[16], l_a[16], l_b[16], l_eq[16], l_cyc[16];
    launch_t e_l;

    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if ((busy == key_ready) || (eq_enable && !op_enable)) begin
                fails++;
                $display("FAIL handshake: got busy=%0d key_ready=%0d eq=%0d op_en=%0d", busy, key_ready, eq_enable, op_enable);
            end
            if (op_enable) begin
                tests++;
                if (l_cnt < 16) begin
                    l_op[l_cnt] = int'(operation_val); l_a[l_cnt] = int'(operator1);
                    l_b[l_cnt] = int'(operator2); l_eq[l_cnt] = int'(eq_enable); l_cyc[l_cnt] = cyc;
                    l_cnt++;
                end
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL launch: got unexpected op_enable op=%0d a=%0d b=%0d, expected none", operation_val, operator1, operator2);
                end else begin
                    e_l = exp_q.pop_front();
                    if (int'(operation_val) != e_l.op || int'(operator1) != e_l.a ||
                        int'(operator2) != e_l.b || int'(eq_enable) != e_l.eq) begin
                        fails++;
                        $display("FAIL launch: got op=%0d a=%0d b=%0d eq=%0d, expected op=%0d a=%0d b=%0d eq=%0d",
                                 operation_val, operator1, operator2, eq_enable, e_l.op, e_l.a, e_l.b, e_l.eq);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int last_accept = 0;

    task automatic send_key(input int k);
        int waited;
        waited = 0;
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k[3:0];
        while (!key_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!key_ready) begin
            tests++;
            fails++;
            $display("FAIL key_accept: got key_ready=0 for 50 cycles, expected 1");
            key_valid = 1'b0;
            return;
        end
        last_accept = cyc + 1;
        @(posedge clk);
        m_key(k);
    endtask

    function automatic int char2key(input byte c);
        case (c)
            "+":     return 10;
            "-":     return 11;
            "*":     return 12;
            "/":     return 13;
            "=":     return 14;
            "c":     return 15;
            default: return int'(c) - 48;
        endcase
    endfunction

    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) send_key(char2key(s[i]));
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        key_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string name);
        idle(4);
        check({name, "_disp"}, int'(display_value), m_disp());
        check({name, "_err"}, int'(error), (m_mode == M_ERR) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    int n;

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; alu_result = '0;
        repeat (2) @(negedge clk);
        check("rst_key_ready", int'(key_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_display", int'(display_value), 0);
        check("rst_op_enable", int'(op_enable), 0);
        check("rst_error", int'(error), 0);
        check("rst_operator1", int'(operator1), 0);
        rst = 1'b0;
        m_reset();

        // 12 + 34 with latency pinning
        l_cnt = 0;
        keys("12+34=");
        n = last_accept;
        idle(2);
        check("t1_disp_early", (display_value == 46) ? 1 : 0, 0);
        @(negedge clk);
        check("t1_disp_n3", int'(display_value), 46);
        check("t1_launches", l_cnt, 1);
        check("t1_launch_cycle", l_cyc[0], n);
        check("t1_op1", l_a[0], 12);
        check("t1_op2", l_b[0], 34);
        check("t1_opval", l_op[0], 0);
        check("t1_eq", l_eq[0], 1);
        keys("+6=");
        check_state("t1_res_op");
        check("t1_res_op_lit", int'(display_value), 52);

        // divide by zero, dropped digit, clear
        l_cnt = 0;
        keys("c9/0=");
        check_state("t2_div0");
        check("t2_err_lit", int'(error), 1);
        check("t2_disp_lit", int'(display_value), 9999);
        check("t2_no_launch", l_cnt, 0);
        keys("5");
        check_state("t2_drop");
        check("t2_drop_lit", int'(display_value), 9999);
        keys("c");
        check_state("t2_clear");
        check("t2_clear_err", int'(error), 0);
        check("t2_clear_disp", int'(display_value), 0);

        // underflow, overflow, boundary
        keys("5-7=");
        check_state("t3_sub");
        check("t3_sub_lit", int'(error), 1);
        keys("c100*100=");
        check_state("t3_mul");
        check("t3_mul_lit", int'(error), 1);
        keys("c99*101=");
        check_state("t4_max");
        check("t4_max_err", int'(error), 0);
        check("t4_max_disp", int'(display_value), 9999);
        keys("c5000+5000=");
        check_state("t4_addovf");
        keys("c7-7=");
        check_state("t4_subeq");

        // chained operators
        l_cnt = 0;
        keys("c2+3*4=");
        check_state("t5_chain");
        check("t5_disp_lit", int'(display_value), 20);
        check("t5_launches", l_cnt, 2);
        check("t5_l0_eq", l_eq[0], 0);
        check("t5_l0_a", l_a[0], 2);
        check("t5_l0_b", l_b[0], 3);
        check("t5_l1_a", l_a[1], 5);
        check("t5_l1_b", l_b[1], 4);
        check("t5_l1_op", l_op[1], 2);
        check("t5_l1_eq", l_eq[1], 1);

        // digit limit, operand B display, operator replacement
        keys("c12345");
        check_state("t6_limit");
        check("t6_limit_lit", int'(display_value), 1234);
        keys("+56");
        check_state("t6_b");
        check("t6_b_lit", int'(display_value), 56);
        keys("c8+-3=");
        check_state("t6_replace");
        check("t6_replace_lit", int'(display_value), 5);

        // key held during busy
        keys("c100/7=");
        n = last_accept;
        keys("3");
        check("t7_hold_edge", last_accept, n + 3);
        check_state("t7_hold");
        check("t7_hold_lit", int'(display_value), 3);

        // async reset during S_WAIT
        l_cnt = 0;
        keys("c1+2=");
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t8_rst_ready", int'(key_ready), 1);
        check("t8_rst_disp", int'(display_value), 0);
        check("t8_rst_op1", int'(operator1), 0);
        check("t8_rst_op2", int'(operator2), 0);
        check("t8_rst_opval", int'(operation_val), 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        check("t8_launch_before", l_cnt, 1);
        keys("=");
        check_state("t8_eq_ignored");
        check("t8_no_launch", l_cnt, 1);
        keys("4");
        check_state("t8_digit");
        check("t8_digit_lit", int'(display_value), 4);

        idle(2);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
